// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file geometry and write-back source indices.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int NREG = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam int GNT_LD = 0;
    localparam int GNT_EX = 1;
endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: LD-over-EX fixed-priority arbiter; EX gets one forced win after MAX_WAIT consecutive losses.
module wb_arbiter import riscv_pkg::*; #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    input  logic       ex_valid,
    output logic [1:0] ready,
    output logic [1:0] grant
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;
    logic ex_win;
    always_comb begin
        // ready reflects who would win, even for a requester that is not valid
        ex_win = !ld_valid || (ex_valid && wait_cnt == CW'(MAX_WAIT));
        ready = '0;
        ready[GNT_EX] = ex_win;
        ready[GNT_LD] = !ex_win;
        grant = '0;
        grant[GNT_EX] = ex_valid && ex_win;
        grant[GNT_LD] = ld_valid && !ex_win;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            wait_cnt <= '0;
        else if (ex_valid && !ex_win)
            wait_cnt <= wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates LD/EX write-back onto the single regfile write port and
// tracks in-flight destinations to stall issue on RAW/WAW hazards.
module regfile_wb_scheduler import riscv_pkg::*; #(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    output logic              iss_ready,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    output logic              ex_ready,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [XLEN-1:0]   wr_data,
    output logic [NREG-1:0]   pending
);
    logic [1:0] rdy, gnt;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;
    logic iss_set;
    logic [NREG-1:0] pend_next;
    wb_arbiter #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .ld_valid(ld_valid),
        .ex_valid(ex_valid),
        .ready   (rdy),
        .grant   (gnt)
    );
    always_comb begin
        ld_ready = rdy[GNT_LD];
        ex_ready = rdy[GNT_EX];
        iss_ready = !(pending[iss_rs1] || pending[iss_rs2] || pending[iss_rd]);
        iss_set = iss_valid && iss_ready && iss_rd != REG_ZERO;
        sel_rd = gnt[GNT_LD] ? ld_rd : ex_rd;
        sel_data = gnt[GNT_LD] ? ld_data : ex_data;
        // WAW blocking guarantees the set and clear never target the same index
        pend_next = ((pending & ~(NREG'(wr_en) << wr_addr)) | (NREG'(iss_set) << iss_rd)) & ~NREG'(1);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pending <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (wr_en)
                assert (pending[wr_addr]);
            pending <= pend_next;
            wr_en <= |gnt && sel_rd != REG_ZERO;
            if (|gnt) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
        end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed hazard/arbitration scenarios then random traffic vs a reference model.
module tb_regfile_wb_scheduler;
    localparam int MAX_WAIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iss_valid, iss_ready, ld_valid, ld_ready, ex_valid, ex_ready, wr_en;
    logic [4:0] iss_rd, iss_rs1, iss_rs2, ld_rd, ex_rd, wr_addr;
    logic [31:0] ld_data, ex_data, wr_data, pending;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] m_pend;
    int m_wait;
    logic m_wr_en;
    logic [4:0] m_wr_addr;
    logic [31:0] m_wr_data;
    bit acc_ld, acc_ex, acc_iss, ld_hold, ex_hold;
    int unsigned outq[$];

    regfile_wb_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_wait = 0;
        m_wr_en = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
    endtask

    task automatic check_regs();
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        chk("wr_data", wr_data, m_wr_data);
        chk("pending", pending, m_pend);
    endtask

    // One clock: check combinational readies, advance the model, check registered outputs.
    task automatic cyc();
        bit ex_wins;
        bit exp_iss;
        #1;
        ex_wins = !ld_valid || (ex_valid && m_wait >= MAX_WAIT);
        exp_iss = !(m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
        chk("iss_ready", 32'(iss_ready), 32'(exp_iss));
        chk("ld_ready", 32'(ld_ready), 32'(!ex_wins));
        chk("ex_ready", 32'(ex_ready), 32'(ex_wins));
        acc_ld = ld_valid && !ex_wins;
        acc_ex = ex_valid && ex_wins;
        acc_iss = iss_valid && exp_iss;
        if (m_wr_en) m_pend[m_wr_addr] = 1'b0;
        if (acc_iss && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        m_wait = (ex_valid && !acc_ex) ? (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT) : 0;
        m_wr_en = 1'b0;
        if (acc_ld) begin
            m_wr_en = ld_rd != 0;
            m_wr_addr = ld_rd;
            m_wr_data = ld_data;
        end else if (acc_ex) begin
            m_wr_en = ex_rd != 0;
            m_wr_addr = ex_rd;
            m_wr_data = ex_data;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        ld_valid = 1;
        #1 chk("rst_ld_only", 32'(ld_ready), 32'd1);
        ld_valid = 0; ex_valid = 1;
        #1 chk("rst_ex_only", 32'(ex_ready), 32'd1);
        ex_valid = 0;
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        // RAW stall on rd=5 until EX write-back lands
        iss_valid = 1; iss_rd = 5;
        cyc();
        chk("t1_pend", pending, 32'h20);
        iss_rd = 0; iss_rs1 = 5;
        ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
        cyc();
        chk("t1_blocked", 32'(iss_ready), 32'd0);
        chk("t1_wr", {wr_en, 26'd0, wr_addr}, {1'b1, 26'd0, 5'd5});
        ex_valid = 0; iss_valid = 0;
        cyc();
        chk("t1_clear", pending, 32'h0);
        chk("t1_unblocked", 32'(iss_ready), 32'd1);
        // Starvation: both valid, EX wins every fifth cycle
        iss_rs1 = 0;
        ld_valid = 1; ld_rd = 0; ex_valid = 1; ex_rd = 0;
        for (int i = 0; i < 10; i++) begin
            ld_data = $urandom; ex_data = $urandom;
            #1;
            chk("t2_ex_ready", 32'(ex_ready), 32'(i % 5 == 4));
            chk("t2_ld_ready", 32'(ld_ready), 32'(i % 5 != 4));
            cyc();
        end
        // x0 write is accepted but dropped
        ex_valid = 0; ld_data = 32'h1234;
        #1 chk("t3_ld_ready", 32'(ld_ready), 32'd1);
        cyc();
        chk("t3_no_wr", 32'(wr_en), 32'd0);
        chk("t3_pend", pending, 32'h0);
        // Independent clears of 3 and 7
        ld_valid = 0; iss_valid = 1; iss_rd = 3;
        cyc();
        iss_rd = 7;
        cyc();
        chk("t4_pend", pending, 32'h88);
        iss_rd = 3; ld_valid = 1; ld_rd = 7; ld_data = $urandom;
        cyc();
        ld_valid = 0;
        cyc();
        chk("t4_pend7", pending, 32'h08);
        chk("t4_blocked", 32'(iss_ready), 32'd0);
        ex_valid = 1; ex_rd = 3; ex_data = $urandom;
        cyc();
        ex_valid = 0;
        cyc();
        chk("t4_pend3", pending, 32'h0);
        chk("t4_unblocked", 32'(iss_ready), 32'd1);
        // Set of 9 and clear of 4 on the same edge
        iss_rd = 4;
        cyc();
        iss_valid = 0; ex_valid = 1; ex_rd = 4; ex_data = $urandom;
        cyc();
        ex_valid = 0; iss_valid = 1; iss_rd = 9;
        cyc();
        chk("t6_pend", pending, 32'h200);
        // Asynchronous reset while a write is on the port
        iss_valid = 0; ex_valid = 1; ex_rd = 9; ex_data = $urandom;
        cyc();
        ex_valid = 0;
        chk("t5_wr_en_pre", 32'(wr_en), 32'd1);
        #2 rst = 0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        check_regs();
        chk("t5_iss_ready", 32'(iss_ready), 32'd1);
        // Random traffic
        ld_hold = 0; ex_hold = 0;
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            int unsigned idx;
            if (!ld_hold) begin
                r = $urandom_range(0, 9);
                if (r < 4 && outq.size() > 0) begin
                    idx = $urandom_range(0, outq.size() - 1);
                    ld_rd = 5'(outq[idx]); outq.delete(idx);
                    ld_valid = 1; ld_data = $urandom;
                end else if (r == 4) begin
                    ld_rd = 0; ld_valid = 1; ld_data = $urandom;
                end else ld_valid = 0;
            end
            if (!ex_hold) begin
                r = $urandom_range(0, 9);
                if (r < 5 && outq.size() > 0) begin
                    idx = $urandom_range(0, outq.size() - 1);
                    ex_rd = 5'(outq[idx]); outq.delete(idx);
                    ex_valid = 1; ex_data = $urandom;
                end else if (r == 5) begin
                    ex_rd = 0; ex_valid = 1; ex_data = $urandom;
                end else ex_valid = 0;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = 5'($urandom_range(0, 15));
            iss_rs1 = 5'($urandom_range(0, 15));
            iss_rs2 = 5'($urandom_range(0, 15));
            cyc();
            if (acc_iss && iss_rd != 0) outq.push_back(iss_rd);
            ld_hold = ld_valid && !acc_ld;
            ex_hold = ex_valid && !acc_ex;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file in the RV32I core.
- Arbitrates write-back requests from two sources, the load unit (LD) and the ALU/execute path (EX), onto that one port.
- Keeps a 32-bit pending-write scoreboard.
- Stalls decode/issue on RAW/WAW hazards against in-flight destinations.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (address width 5)
MAX_WAIT, 4, consecutive EX losses before EX is forced priority for one cycle (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
iss_valid  in  1  decode presents an instruction
iss_rd  in  5  destination register (0 = no write)
iss_rs1  in  5  source 1 address
iss_rs2  in  5  source 2 address
iss_ready  out  1  instruction may issue; no hazard
ld_valid  in  1  load write-back request
ld_rd  in  5  load destination
ld_data  in  32  load result
ld_ready  out  1  load request accepted this cycle
ex_valid  in  1  ALU write-back request
ex_rd  in  5  ALU destination
ex_data  in  32  ALU result
ex_ready  out  1  ALU request accepted this cycle
wr_en  out  1  register-file write enable (writeControl)
wr_addr  out  5  register-file Rd_addr
wr_data  out  32  register-file Write_Rd_data
pending  out  32  scoreboard, for debug and perf counters

Behaviour:
- Reset (rst=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, pending=0, starvation counter=0.
  - Ready outputs depend only on registered state and inputs, so after reset iss_ready=iss_valid-independent 1, and ld_ready/ex_ready=1 when only one source requests.
  - Reset mid-operation discards any granted-but-unwritten write (wr_en forced 0). In-flight requesters must be flushed by their own reset.
- Issue/scoreboard:
  - hazard = pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd].
  - iss_ready = ~hazard, evaluated combinationally from registered pending only. There is no same-cycle bypass of a clear.
  - On iss_valid & iss_ready & iss_rd!=0: pending[iss_rd] sets at that edge.
  - pending[0] is hardwired 0. Reads of x0 never hazard.
- Arbitration (combinational grant, one per cycle):
  - Default priority is LD over EX.
  - The starvation counter increments each cycle EX is valid and not granted. It clears when EX is granted or ex_valid=0, and saturates at MAX_WAIT.
  - When counter==MAX_WAIT and ex_valid=1, EX is granted and LD is held (ld_ready=0).
  - Only one of ld_ready/ex_ready is high per cycle. A requester not valid gets ready=1 only if it would win.
  - A handshake completes on valid & ready. The requester must hold rd/data stable while valid & ~ready.
- Write port (registered, latency 1):
  - A grant at edge N drives wr_en=1, wr_addr=rd, wr_data=data during cycle N+1.
  - With no grant, wr_en=0; wr_addr and wr_data hold their last values.
  - A grant with rd=0 completes the handshake but drives wr_en=0 (x0 writes dropped).
- Pending clear: pending[wr_addr] clears at the edge ending a cycle with wr_en=1.
  - The register file is written that same cycle, so the first cycle iss_ready can rise sees the new value.
- Simultaneous events:
  - A set and a clear of the same index in one edge cannot occur, because WAW blocks the issue.
  - Set and clear of different indices both take effect.
  - A write-back to a non-pending register is a protocol error (asserted in simulation); the write is still performed.

Decomposition:
- Shared package (riscv_pkg): XLEN, REG_AW=5, NREG, REG_ZERO=5'd0.
- One sub-module, wb_arbiter: a 2-request fixed-priority arbiter with starvation counter, parameterised by MAX_WAIT, outputting the grant vector.
- Scoreboard and write register stay in the top module.

Test Plan:
1. Reset then issue rd=5 with iss_valid=1: pending=0x20 next cycle. Issuing rs1=5 gives iss_ready=0. EX writes rd=5 data=0xDEADBEEF; wr_en=1 one cycle later with wr_addr=5, and the cycle after that pending=0 and iss_ready=1.
2. LD and EX both valid continuously, MAX_WAIT=4: LD is granted 4 cycles, EX on the 5th, and the pattern repeats. Never both ready.
3. LD valid with rd=0, data=0x1234: ld_ready=1, wr_en stays 0, pending unchanged.
4. Issue rd=3, then rd=7; LD completes 7 while EX completes 3 in a later cycle: each clears only its own bit. Issuing rd=3 stays blocked until bit 3 clears.
5. rst driven low mid-cycle while wr_en=1: outputs go to 0 immediately without a clock edge. After release, pending=0 and iss_ready=1.
6. Issue rd=9 in the same cycle wr_en=1 clears rd=4: the edge leaves pending=0x200.
